// File: rtl/dl_stream_demux2_if.sv
// Stream bundle for the 1-to-2 demultiplexer: one valid/ready input stream
// with a per-beat destination select, and two valid/ready output streams.
//   in_valid/in_ready/in_data/in_sel     : producer side
//   out0_valid/out0_ready/out0_data      : consumer 0
//   out1_valid/out1_ready/out1_data      : consumer 1
// Modports: slave = the demux itself, master = the surrounding environment.
interface dl_stream_demux2_if #(
  parameter int unsigned NUM_BITS = 32
);
  logic                in_valid;
  logic                in_ready;
  logic [NUM_BITS-1:0] in_data;
  logic                in_sel;
  logic                out0_valid;
  logic                out0_ready;
  logic [NUM_BITS-1:0] out0_data;
  logic                out1_valid;
  logic                out1_ready;
  logic [NUM_BITS-1:0] out1_data;

  modport slave (
    input  in_valid, in_data, in_sel, out0_ready, out1_ready,
    output in_ready, out0_valid, out0_data, out1_valid, out1_data
  );

  modport master (
    output in_valid, in_data, in_sel, out0_ready, out1_ready,
    input  in_ready, out0_valid, out0_data, out1_valid, out1_data
  );
endinterface

// File: rtl/dl_stream_demux2.sv
// 1-to-2 stream demultiplexer. Each accepted input beat is steered by in_sel
// into a private 2-entry skid buffer per output, so a stalled consumer only
// blocks beats headed to itself.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset; clears counts, pointers and entries
//   bus  : dl_stream_demux2_if.slave (input stream + two output streams)
// Optional feature (macro DL_STREAM_DEMUX2_STATS_EN):
//   out0_count/out1_count : 32-bit wrapping counters of completed reads per output
module dl_stream_demux2 #(
  parameter int unsigned NUM_BITS = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  dl_stream_demux2_if.slave      bus
`ifdef DL_STREAM_DEMUX2_STATS_EN
  ,
  output logic [31:0]            out0_count,
  output logic [31:0]            out1_count
`endif
);

  localparam int unsigned NUM_OUTS = 2;
  localparam int unsigned DEPTH    = 2;
  localparam int unsigned CNT_W    = 2;

  logic [NUM_BITS-1:0] entry_q [NUM_OUTS][DEPTH];
  logic [NUM_BITS-1:0] entry_d [NUM_OUTS][DEPTH];
  logic [NUM_OUTS-1:0] wp_q, wp_d;
  logic [NUM_OUTS-1:0] rp_q, rp_d;
  logic [CNT_W-1:0]    cnt_q [NUM_OUTS];
  logic [CNT_W-1:0]    cnt_d [NUM_OUTS];

  logic                in_ready_c;
  logic [NUM_OUTS-1:0] out_ready_c;
  logic [NUM_OUTS-1:0] out_valid_c;
  logic [NUM_OUTS-1:0] wr_c;
  logic [NUM_OUTS-1:0] rd_c;

  // Handshake decode; in_ready looks only at the selected buffer's registered
  // count, never at consumer ready, so there is no ready path through the demux.
  always_comb begin
    out_ready_c = {bus.out1_ready, bus.out0_ready};
    in_ready_c  = bus.in_sel ? (cnt_q[1] < CNT_W'(DEPTH)) : (cnt_q[0] < CNT_W'(DEPTH));
    out_valid_c = '0;
    wr_c        = '0;
    rd_c        = '0;
    for (int k = 0; k < int'(NUM_OUTS); k++) begin
      out_valid_c[k] = (cnt_q[k] != '0);
      wr_c[k]        = bus.in_valid && in_ready_c && (bus.in_sel == 1'(k));
      rd_c[k]        = out_valid_c[k] && out_ready_c[k];
    end
  end

  // Next-state for both skid buffers.
  always_comb begin
    entry_d = entry_q;
    wp_d    = wp_q;
    rp_d    = rp_q;
    cnt_d   = cnt_q;
    for (int k = 0; k < int'(NUM_OUTS); k++) begin
      if (wr_c[k]) begin
        entry_d[k][wp_q[k]] = bus.in_data;
        wp_d[k]             = ~wp_q[k];
      end
      if (rd_c[k]) begin
        rp_d[k] = ~rp_q[k];
      end
      // Simultaneous write and read leaves the count unchanged.
      cnt_d[k] = cnt_q[k] + CNT_W'(wr_c[k]) - CNT_W'(rd_c[k]);
    end
  end

  // Buffer state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < int'(NUM_OUTS); k++) begin
        for (int e = 0; e < int'(DEPTH); e++) begin
          entry_q[k][e] <= '0;
        end
        cnt_q[k] <= '0;
      end
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      entry_q <= entry_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.out0_valid = out_valid_c[0];
  assign bus.out1_valid = out_valid_c[1];
  assign bus.out0_data  = entry_q[0][rp_q[0]];
  assign bus.out1_data  = entry_q[1][rp_q[1]];

`ifdef DL_STREAM_DEMUX2_STATS_EN
  localparam int unsigned STAT_W = 32;

  logic [STAT_W-1:0] stat_q [NUM_OUTS];
  logic [STAT_W-1:0] stat_d [NUM_OUTS];

  // Completed-read counters; wrap naturally at 2^32.
  always_comb begin
    stat_d = stat_q;
    for (int k = 0; k < int'(NUM_OUTS); k++) begin
      stat_d[k] = stat_q[k] + STAT_W'(rd_c[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < int'(NUM_OUTS); k++) begin
        stat_q[k] <= '0;
      end
    end else begin
      stat_q <= stat_d;
    end
  end

  assign out0_count = stat_q[0];
  assign out1_count = stat_q[1];
`endif

endmodule

// File: tb/tb_dl_stream_demux2.sv
// Self-checking bench for dl_stream_demux2. Reference model: one FIFO queue
// per output holding at most two beats; input accepted when the selected
// queue holds fewer than two.
module tb_dl_stream_demux2;

  localparam int unsigned NUM_BITS = 32;

  logic clk;
  logic rst;

  dl_stream_demux2_if #(.NUM_BITS(NUM_BITS)) bus ();

`ifdef DL_STREAM_DEMUX2_STATS_EN
  logic [31:0] out0_count;
  logic [31:0] out1_count;
`endif

  dl_stream_demux2 #(.NUM_BITS(NUM_BITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef DL_STREAM_DEMUX2_STATS_EN
    ,
    .out0_count (out0_count),
    .out1_count (out1_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_err;

  logic [NUM_BITS-1:0] q0[$];
  logic [NUM_BITS-1:0] q1[$];

  // Advance model by one clock using the inputs currently applied, then
  // step the DUT and wait just past the edge.
  task automatic tick();
    bit acc;
    bit r0;
    bit r1;
    acc = bus.in_valid && (bus.in_sel ? (q1.size() < 2) : (q0.size() < 2));
    r0  = (q0.size() != 0) && bus.out0_ready;
    r1  = (q1.size() != 0) && bus.out1_ready;
    if (rst) begin
      q0.delete();
      q1.delete();
    end else begin
      if (r0) void'(q0.pop_front());
      if (r1) void'(q1.pop_front());
      if (acc) begin
        if (bus.in_sel) q1.push_back(bus.in_data);
        else            q0.push_back(bus.in_data);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid   = 1'b0;
    bus.in_sel     = 1'b0;
    bus.in_data    = '0;
    bus.out0_ready = 1'b0;
    bus.out1_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    do_reset();
    #1;
    n_cmp++; if (bus.out0_valid !== 1'b0) begin n_err++; $display("FAIL reset_out0_valid got %b exp 0", bus.out0_valid); end
    n_cmp++; if (bus.out1_valid !== 1'b0) begin n_err++; $display("FAIL reset_out1_valid got %b exp 0", bus.out1_valid); end
    n_cmp++; if (bus.out0_data !== 32'h0) begin n_err++; $display("FAIL reset_out0_data got %h exp 0", bus.out0_data); end
    n_cmp++; if (bus.out1_data !== 32'h0) begin n_err++; $display("FAIL reset_out1_data got %h exp 0", bus.out1_data); end
    bus.in_sel = 1'b0; #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready_sel0 got %b exp 1", bus.in_ready); end
    bus.in_sel = 1'b1; #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready_sel1 got %b exp 1", bus.in_ready); end
    bus.in_sel = 1'b0;
  endtask

  task automatic test_first_beat();
    idle_inputs();
    bus.in_valid = 1'b1; bus.in_sel = 1'b0; bus.in_data = 32'h11; bus.out0_ready = 1'b1;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL first_in_ready got %b exp 1", bus.in_ready); end
    n_cmp++; if (bus.out0_valid !== 1'b0) begin n_err++; $display("FAIL first_out0_pre got %b exp 0", bus.out0_valid); end
    tick();
    bus.in_valid = 1'b0;
    #1;
    n_cmp++; if (bus.out0_valid !== 1'b1) begin n_err++; $display("FAIL first_out0_valid got %b exp 1", bus.out0_valid); end
    n_cmp++; if (bus.out0_data !== 32'h11) begin n_err++; $display("FAIL first_out0_data got %h exp 11", bus.out0_data); end
    n_cmp++; if (bus.out1_valid !== 1'b0) begin n_err++; $display("FAIL first_out1_valid got %b exp 0", bus.out1_valid); end
    tick();
    #1;
    n_cmp++; if (bus.out0_valid !== 1'b0) begin n_err++; $display("FAIL first_out0_drained got %b exp 0", bus.out0_valid); end
  endtask

  task automatic test_stream();
    logic [NUM_BITS-1:0] exp;
    idle_inputs();
    bus.out1_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1; bus.in_sel = 1'b1; bus.in_data = 32'hA0 + NUM_BITS'(i);
      #1;
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL stream_in_ready beat %0d got %b exp 1", i, bus.in_ready); end
      if (i > 0) begin
        exp = 32'hA0 + NUM_BITS'(i - 1);
        n_cmp++; if (bus.out1_valid !== 1'b1 || bus.out1_data !== exp) begin n_err++; $display("FAIL stream_out1 beat %0d got v=%b d=%h exp v=1 d=%h", i, bus.out1_valid, bus.out1_data, exp); end
      end
      tick();
    end
    bus.in_valid = 1'b0;
    #1;
    n_cmp++; if (bus.out1_valid !== 1'b1 || bus.out1_data !== 32'hA7) begin n_err++; $display("FAIL stream_out1_last got v=%b d=%h exp v=1 d=a7", bus.out1_valid, bus.out1_data); end
    tick();
    #1;
    n_cmp++; if (bus.out1_valid !== 1'b0) begin n_err++; $display("FAIL stream_out1_empty got %b exp 0", bus.out1_valid); end
  endtask

  task automatic test_backpressure();
    idle_inputs();
    bus.in_valid = 1'b1; bus.in_sel = 1'b0; bus.in_data = 32'h01; tick();
    bus.in_data = 32'h02; tick();
    bus.in_data = 32'h99; #1;
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_full_in_ready got %b exp 0", bus.in_ready); end
    tick();
    bus.in_sel = 1'b1; bus.in_data = 32'h03; #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL bp_other_in_ready got %b exp 1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0; #1;
    n_cmp++; if (bus.out1_valid !== 1'b1 || bus.out1_data !== 32'h03) begin n_err++; $display("FAIL bp_out1 got v=%b d=%h exp v=1 d=03", bus.out1_valid, bus.out1_data); end
    n_cmp++; if (bus.out0_valid !== 1'b1 || bus.out0_data !== 32'h01) begin n_err++; $display("FAIL bp_out0_held got v=%b d=%h exp v=1 d=01", bus.out0_valid, bus.out0_data); end
    bus.out0_ready = 1'b1; tick();
    #1;
    n_cmp++; if (bus.out0_valid !== 1'b1 || bus.out0_data !== 32'h02) begin n_err++; $display("FAIL bp_out0_second got v=%b d=%h exp v=1 d=02", bus.out0_valid, bus.out0_data); end
    tick();
    #1;
    n_cmp++; if (bus.out0_valid !== 1'b0) begin n_err++; $display("FAIL bp_out0_empty got %b exp 0", bus.out0_valid); end
    bus.out1_ready = 1'b1; tick();
  endtask

  task automatic test_rw_same();
    idle_inputs();
    bus.in_valid = 1'b1; bus.in_sel = 1'b0; bus.in_data = 32'h05; tick();
    bus.in_data = 32'h06; bus.out0_ready = 1'b1; #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rw_in_ready got %b exp 1", bus.in_ready); end
    n_cmp++; if (bus.out0_valid !== 1'b1 || bus.out0_data !== 32'h05) begin n_err++; $display("FAIL rw_first got v=%b d=%h exp v=1 d=05", bus.out0_valid, bus.out0_data); end
    tick();
    bus.in_valid = 1'b0; #1;
    n_cmp++; if (bus.out0_valid !== 1'b1 || bus.out0_data !== 32'h06) begin n_err++; $display("FAIL rw_second got v=%b d=%h exp v=1 d=06", bus.out0_valid, bus.out0_data); end
    tick();
    #1;
    n_cmp++; if (bus.out0_valid !== 1'b0) begin n_err++; $display("FAIL rw_empty got %b exp 0", bus.out0_valid); end
  endtask

  task automatic test_mid_reset();
    idle_inputs();
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_sel = 1'(i); bus.in_data = 32'hD0 + NUM_BITS'(i); tick();
    end
    bus.in_valid = 1'b0; #1;
    n_cmp++; if (bus.out0_valid !== 1'b1 || bus.out1_valid !== 1'b1) begin n_err++; $display("FAIL mrst_pre_valid got %b%b exp 11", bus.out1_valid, bus.out0_valid); end
    do_reset();
    #1;
    n_cmp++; if (bus.out0_valid !== 1'b0 || bus.out1_valid !== 1'b0) begin n_err++; $display("FAIL mrst_valid got %b%b exp 00", bus.out1_valid, bus.out0_valid); end
    bus.in_sel = 1'b0; #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL mrst_in_ready_sel0 got %b exp 1", bus.in_ready); end
    bus.in_sel = 1'b1; #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL mrst_in_ready_sel1 got %b exp 1", bus.in_ready); end
    bus.out0_ready = 1'b1; bus.out1_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      n_cmp++; if (bus.out0_valid !== 1'b0 || bus.out1_valid !== 1'b0) begin n_err++; $display("FAIL mrst_ghost cycle %0d got %b%b exp 00", i, bus.out1_valid, bus.out0_valid); end
    end
  endtask

  task automatic test_random();
    bit exp_rdy;
    bit stall;
    idle_inputs();
    stall = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!stall) begin
        bus.in_valid = 1'($urandom_range(0, 3) != 0);
        bus.in_sel   = 1'($urandom);
        bus.in_data  = NUM_BITS'($urandom);
      end
      bus.out0_ready = 1'($urandom_range(0, 2) != 0);
      bus.out1_ready = 1'($urandom_range(0, 3) == 0);
      rst = 1'($urandom_range(0, 99) == 0);
      #1;
      exp_rdy = bus.in_sel ? (q1.size() < 2) : (q0.size() < 2);
      n_cmp++; if (bus.in_ready !== exp_rdy) begin n_err++; $display("FAIL rnd_in_ready cyc %0d got %b exp %b", i, bus.in_ready, exp_rdy); end
      n_cmp++; if (bus.out0_valid !== (q0.size() != 0)) begin n_err++; $display("FAIL rnd_out0_valid cyc %0d got %b exp %b", i, bus.out0_valid, q0.size() != 0); end
      n_cmp++; if (bus.out1_valid !== (q1.size() != 0)) begin n_err++; $display("FAIL rnd_out1_valid cyc %0d got %b exp %b", i, bus.out1_valid, q1.size() != 0); end
      if (q0.size() != 0) begin
        n_cmp++; if (bus.out0_data !== q0[0]) begin n_err++; $display("FAIL rnd_out0_data cyc %0d got %h exp %h", i, bus.out0_data, q0[0]); end
      end
      if (q1.size() != 0) begin
        n_cmp++; if (bus.out1_data !== q1[0]) begin n_err++; $display("FAIL rnd_out1_data cyc %0d got %h exp %h", i, bus.out1_data, q1[0]); end
      end
      // Producer must hold a refused beat; a reset cancels it.
      stall = bus.in_valid && !exp_rdy && !rst;
      tick();
    end
    rst = 1'b0;
  endtask

`ifdef DL_STREAM_DEMUX2_STATS_EN
  task automatic test_stats();
    idle_inputs();
    do_reset();
    bus.out0_ready = 1'b1; bus.out1_ready = 1'b1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.in_sel = 1'(i >= 5); bus.in_data = NUM_BITS'(i); tick();
    end
    bus.in_valid = 1'b0;
    tick(); tick();
    #1;
    n_cmp++; if (out0_count !== 32'd5) begin n_err++; $display("FAIL stats_out0_count got %0d exp 5", out0_count); end
    n_cmp++; if (out1_count !== 32'd3) begin n_err++; $display("FAIL stats_out1_count got %0d exp 3", out1_count); end
    do_reset();
    #1;
    n_cmp++; if (out0_count !== 32'd0 || out1_count !== 32'd0) begin n_err++; $display("FAIL stats_reset got %0d/%0d exp 0/0", out0_count, out1_count); end
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    idle_inputs();
    @(posedge clk);
    #1;
    test_reset();
    test_first_beat();
    test_stream();
    test_backpressure();
    test_rw_same();
    test_mid_reset();
    test_random();
`ifdef DL_STREAM_DEMUX2_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dl_stream_demux2.md
Name: dl_stream_demux2

Overview:
- Parameterized 1-to-2 stream demultiplexer: the routing counterpart of the library 2-to-1 mux.
- Accepts one valid/ready input stream and steers each beat to output 0 or 1 according to a per-beat select.
- Each output has its own 2-entry skid buffer, so a stalled consumer does not block beats headed to the other output once that beat has been accepted.
- Used in the core to split one producer between two consumers, e.g. writeback result to the register file vs. the CSR unit, or fetch responses to the decode vs. the prefetch path.

Parameters:
- NUM_BITS, 32, width of the data payload.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input beat present.
- in_ready  output  1  input beat accepted this cycle when high together with in_valid.
- in_data  input  NUM_BITS  input payload.
- in_sel  input  1  destination of the current beat: 0 selects out0, 1 selects out1.
- out0_valid  output  1  out0 holds a beat.
- out0_ready  input  1  out0 consumer accepts.
- out0_data  output  NUM_BITS  out0 payload.
- out1_valid  output  1  out1 holds a beat.
- out1_ready  input  1  out1 consumer accepts.
- out1_data  output  NUM_BITS  out1 payload.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Per-output buffer k (k = 0, 1):
  - 2 entries, write pointer wp_k (1 bit), read pointer rp_k (1 bit), count_k in 0..2.
- Input handshake:
  - in_ready = (in_sel == 0) ? (count_0 < 2) : (count_1 < 2).
  - in_ready depends only on in_sel and registered counts; it never depends on out*_ready.
  - The producer holds in_data and in_sel stable while in_valid && !in_ready.
- Write and read events:
  - wr_k = in_valid && in_ready && (in_sel == k).
  - rd_k = outk_valid && outk_ready.
- Write on wr_k: entry[wp_k] <= in_data; wp_k toggles.
- Read on rd_k: rp_k toggles.
- Count update:
  - count_k <= count_k + wr_k − rd_k.
  - Simultaneous wr_k and rd_k at count 1 leaves count at 1 with the pointers advanced.
  - Write while full is impossible, because in_ready is low.
- Outputs:
  - outk_valid = (count_k != 0).
  - outk_data = entry[rp_k].
  - outk_data is don't-care when outk_valid is low, but it is 0 after reset.
- Latency and ordering:
  - Latency is 1 cycle: a beat accepted in cycle N appears on outk in cycle N+1 if buffer k was empty.
  - Order is preserved within each output. No ordering is guaranteed between the two outputs.
- Throughput: 1 beat/cycle sustained to either output while its consumer holds ready high.
- Backpressure isolation: when out0 is stalled and buffer 0 is full, beats with in_sel=1 are still accepted whenever count_1 < 2.
- Reset:
  - All counts, pointers and entries clear to 0.
  - out0_valid = out1_valid = 0; in_ready = 1 for either sel value.
  - Reset mid-operation discards all buffered beats. No beat accepted before reset appears afterwards.
- Valid rules:
  - outk_valid, once high, stays high with stable outk_data until rd_k.
  - in_valid low: no state change except reads.

Optional Feature:
- Macro: DL_STREAM_DEMUX2_STATS_EN.
- When defined, two extra output ports are added: out0_count and out1_count, each 32 bits.
  - Each port counts completed rd_k handshakes and wraps from 0xFFFFFFFF to 0.
  - Both counters clear on rst.
- When undefined, neither the ports nor the counter logic exist, and the core behaviour is unchanged.

Test Plan:
- Reset, then in_valid=1, in_sel=0, in_data=0x11, out0_ready=1 -> the next cycle shows out0_valid=1 and out0_data=0x11; out1_valid stays 0.
- Stream 0xA0..0xA7 to sel=1 with out1_ready=1 -> in_ready held at 1 and out1_data emits 0xA0..0xA7 in consecutive cycles starting one cycle later.
- Backpressure isolation:
  - Setup: out0_ready=0; send 0x01, 0x02 to sel=0.
  - Expect: in_ready=0 for sel=0 with count_0=2.
  - Then send 0x03 to sel=1 -> accepted, out1_data=0x03.
  - Then raise out0_ready -> out0 emits 0x01 followed by 0x02.
- Simultaneous read/write at count 1 on out0 (0x05 held, 0x06 written, out0_ready=1) -> out0_data=0x05 then 0x06, with no bubble and no loss.
- Assert rst while both buffers hold 2 beats -> the next cycle shows out0_valid=out1_valid=0 and in_ready=1; the pre-reset data never reappears.
- With DL_STREAM_DEMUX2_STATS_EN: 5 reads on out0 and 3 on out1 -> out0_count=5 and out1_count=3; after rst both read 0.
